// File: rtl/switch_debounce_pkg.sv
// Shared constants and per-bit state type for the switch debouncer.
package switch_pkg;

  localparam int CLK_HZ                  = 48_000_000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } db_state_t;

endpackage

// File: rtl/switch_debounce_if.sv
// Switch-side bundle: raw pins in, debounced value and change strobe out.
interface switch_debounce_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] s_raw;
  logic [WIDTH-1:0] s_db;
  logic             s_chg;
  logic [WIDTH-1:0] s_chg_mask;

  modport master (
    output s_raw,
    input  s_db,
    input  s_chg,
    input  s_chg_mask
  );

  modport slave (
    input  s_raw,
    output s_db,
    output s_chg,
    output s_chg_mask
  );

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-flop synchronizer, stable-time counter and IDLE/QUAL FSM.
// Defining DEBOUNCE_BYPASS_EN replaces the counter/FSM with a plain register.
module debounce_bit
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_db,
  output logic o_load
);

  logic [1:0] r_sync;
  logic       w_sync;
  logic       r_db;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], i_raw};
  end

  assign w_sync = r_sync[1];
  assign o_db   = r_db;

`ifdef DEBOUNCE_BYPASS_EN

  always_ff @(posedge clk) begin
    if (reset) r_db <= 1'b0;
    else       r_db <= w_sync;
  end

  assign o_load = (w_sync != r_db);

`else

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  db_state_t     r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          w_db_next;
  logic          w_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_db    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_db    <= w_db_next;
    end
  end

  // The counter counts mismatching cycles including the one that leaves IDLE,
  // so the update lands exactly DEBOUNCE_CYCLES edges after s_sync changes.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_db_next    = r_db;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (w_sync != r_db) begin
          w_state_next = QUAL;
          w_cnt_next   = CW'(1);
        end
      end
      QUAL: begin
        if (w_sync == r_db) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == LAST) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
          w_db_next    = w_sync;
          w_load       = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_load = w_load;

`endif

endmodule

// File: rtl/switch_debounce.sv
// Switch debouncer top: per-bit conditioners plus the registered change strobe.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  switch_debounce_if.slave  sw
);

  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] w_load;
  logic             r_chg;
  logic [WIDTH-1:0] r_chg_mask;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (sw.s_raw[gi]),
        .o_db   (w_db[gi]),
        .o_load (w_load[gi])
      );
    end
  endgenerate

  // Load strobes are registered on the same edge that updates s_db.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chg      <= 1'b0;
      r_chg_mask <= '0;
    end else begin
      r_chg      <= |w_load;
      r_chg_mask <= w_load;
    end
  end

  assign sw.s_db       = w_db;
  assign sw.s_chg      = r_chg;
  assign sw.s_chg_mask = r_chg_mask;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with a change-event scoreboard.
module tb_switch_debounce;

  localparam int W  = 4;
  localparam int DC = 8;
`ifdef DEBOUNCE_BYPASS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = DC + 2;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] mask;
    logic [3:0] db;
  } ev_t;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic rst_seen = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  logic [3:0] prev_db = 4'h0;
  ev_t  sb_q[$];

  switch_debounce_if #(.WIDTH(W)) swif ();

  switch_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (swif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  // Monitor: every s_chg pops one expected event; other cycles must be quiet.
  always @(negedge clk) begin
    ev_t e;
    if (rst_seen) begin
      prev_db = swif.s_db;
    end else begin
      if (swif.s_chg === 1'b1) begin
        checks++;
        assert (sb_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_chg cyc=%0d observed mask=%h required no pulse", cyc, swif.s_chg_mask);
        end
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          checks += 3;
          assert (cyc === e.cyc) else begin
            failures++;
            $error("FAIL chg_cycle observed=%0d expected=%0d", cyc, e.cyc);
          end
          assert (swif.s_chg_mask === e.mask) else begin
            failures++;
            $error("FAIL chg_mask cyc=%0d observed=%h expected=%h", cyc, swif.s_chg_mask, e.mask);
          end
          assert (swif.s_db === e.db) else begin
            failures++;
            $error("FAIL chg_db cyc=%0d observed=%h expected=%h", cyc, swif.s_db, e.db);
          end
        end
      end else begin
        checks++;
        assert (swif.s_chg === 1'b0 && swif.s_chg_mask === 4'h0 && swif.s_db === prev_db) else begin
          failures++;
          $error("FAIL quiet_cycle cyc=%0d observed chg=%b mask=%h db=%h expected chg=0 mask=0 db=%h",
                 cyc, swif.s_chg, swif.s_chg_mask, swif.s_db, prev_db);
        end
      end
      prev_db = swif.s_db;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_chg(input logic [3:0] mask, input logic [3:0] db);
    ev_t e;
    e.cyc  = cyc + LAT;
    e.mask = mask;
    e.db   = db;
    sb_q.push_back(e);
    $display("expect cyc=%0d mask=%h db=%h", e.cyc, mask, db);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    swif.s_raw = 4'hF;
    tick(3);
    check("reset_db", 32'(swif.s_db), 32'h0);
    check("reset_chg", 32'(swif.s_chg), 32'h0);
    check("reset_mask", 32'(swif.s_chg_mask), 32'h0);
    reset = 1'b0;
    expect_chg(4'hF, 4'hF);
    tick(LAT + 4);

    swif.s_raw = 4'h0;
    expect_chg(4'hF, 4'h0);
    tick(LAT + 4);

    swif.s_raw = 4'hA;
    expect_chg(4'hA, 4'hA);
    tick(LAT + 4);

    swif.s_raw = 4'h1;
    expect_chg(4'hB, 4'h1);
    tick(LAT + 4);

`ifndef DEBOUNCE_BYPASS_EN
    // Short pulse on bit 2 must be rejected.
    swif.s_raw = 4'h5;
    tick(5);
    swif.s_raw = 4'h1;
    tick(15);
    check("glitch_db", 32'(swif.s_db), 32'h1);

    // Bit 1 chatters with a 4-cycle half period, then settles high.
    for (int t = 0; t < 50; t++) begin
      swif.s_raw = swif.s_raw ^ 4'h2;
      tick(4);
    end
    check("chatter_db", 32'(swif.s_db), 32'h1);
    swif.s_raw = 4'h3;
    expect_chg(4'h2, 4'h3);
    tick(LAT + 4);

    swif.s_raw = 4'h0;
    expect_chg(4'h3, 4'h0);
    tick(LAT + 4);

    // Reset lands while both bits are mid-qualification (counter=5).
    swif.s_raw = 4'h3;
    tick(7);
    reset = 1'b1;
    tick(1);
    check("midq_reset_db", 32'(swif.s_db), 32'h0);
    check("midq_reset_chg", 32'(swif.s_chg), 32'h0);
    reset = 1'b0;
    expect_chg(4'h3, 4'h3);
    tick(LAT + 4);
    check("requal_db", 32'(swif.s_db), 32'h3);

    swif.s_raw = 4'hC;
    expect_chg(4'hF, 4'hC);
    tick(LAT + 4);
`endif

    tick(5);
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of switch inputs conditioned.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 480_000 (10 ms at 48 MHz), giving the stable-time qualification in clk cycles; legal range is 2 to 2^24-1.
REQ-003 The block SHALL have port clk, input, 1 bit, the 48 MHz oscillator clock; the block uses only this clock.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port s_raw, input, WIDTH bits, the asynchronous switch pins.
REQ-006 The block SHALL have port s_db, output, WIDTH bits, the debounced switch value that feeds the seven-segment decoder and LED logic.
REQ-007 The block SHALL have port s_chg, output, 1 bit, a one-cycle pulse when any bit of s_db changes.
REQ-008 The block SHALL have port s_chg_mask, output, WIDTH bits, the bits of s_db that changed in the s_chg cycle; it is zero otherwise.

Function
REQ-009 Each s_raw bit SHALL pass through a 2-flop synchronizer (s_sync) before any other use.
REQ-010 Each bit SHALL have its own counter and a two-state FSM: IDLE (s_sync[i]==s_db[i], counter held at 0) and QUAL (s_sync[i]!=s_db[i], counter incrementing by 1 per cycle).
REQ-011 IDLE->QUAL SHALL occur on the first cycle that s_sync[i]!=s_db[i].
REQ-012 QUAL->IDLE without an update SHALL occur on any cycle that s_sync[i]==s_db[i], clearing the counter; this rejects glitches shorter than DEBOUNCE_CYCLES.
REQ-013 In QUAL, when counter==DEBOUNCE_CYCLES-1, the next edge SHALL load s_db[i]<=s_sync[i], clear the counter and return to IDLE.
REQ-014 Latency: a clean step on s_raw[i] sampled at edge k SHALL appear on s_db[i] after edge k+1+DEBOUNCE_CYCLES.
REQ-015 Counter width SHALL be $clog2(DEBOUNCE_CYCLES) bits, and the counter SHALL never wrap, because REQ-013 clears it first.
REQ-016 s_chg and s_chg_mask SHALL be registered and asserted on the same cycle that the new s_db value first appears.
REQ-017 When several bits qualify on the same edge, the block SHALL issue one s_chg pulse with all of those bits set in s_chg_mask.
REQ-018 A bit that toggles continuously faster than DEBOUNCE_CYCLES SHALL leave its s_db bit unchanged indefinitely.

Reset
REQ-019 While reset is high at a clk edge, the block SHALL clear s_sync, s_db, all counters, s_chg and s_chg_mask to 0 and set every FSM to IDLE.
REQ-020 A reset asserted during QUAL SHALL abandon the qualification; after reset releases, a held-high s_raw bit SHALL requalify from zero and take the full REQ-014 latency.

Configuration
REQ-021 When DEBOUNCE_BYPASS_EN is defined, the block SHALL remove the counters and FSMs, register s_sync directly into s_db (pin-to-s_db latency 3 edges), and keep s_chg/s_chg_mask behaving per REQ-016/017.
REQ-022 When DEBOUNCE_BYPASS_EN is undefined, the block SHALL behave per REQ-009..REQ-018; synthesis builds leave it undefined.

Structure
REQ-023 Package switch_pkg SHALL hold CLK_HZ=48_000_000, DEBOUNCE_MS=10, the derived DEBOUNCE_CYCLES default and the per-bit state enum typedef db_state_t {IDLE, QUAL}.
REQ-024 Per-bit logic (synchronizer, counter, FSM) SHALL be one sub-module debounce_bit, instantiated WIDTH times by a generate loop.
REQ-025 The top SHALL hold only the change-detect registers.

Verification (bench uses DEBOUNCE_CYCLES=8, WIDTH=4)
REQ-026 Reset high 3 cycles with s_raw=4'hF -> s_db=0, s_chg=0; after release, s_db=4'hF after 10 edges, with one s_chg pulse and s_chg_mask=4'hF.
REQ-027 s_raw[0] 0->1 held -> s_db[0]=1 after exactly edge k+9, s_chg_mask=4'b0001 for 1 cycle.
REQ-028 s_raw[2] high for 5 cycles then low -> s_db stays 0 and s_chg never asserts.
REQ-029 s_raw[1] toggling every 4 cycles for 200 cycles -> s_db[1] constant 0; then hold high -> update 9 edges later.
REQ-030 Reset pulsed at counter=5 with s_raw=4'h3 held -> no update; s_db=4'h3 exactly 10 edges after reset release.
REQ-031 With DEBOUNCE_BYPASS_EN, s_raw 0->4'hA -> s_db=4'hA after 3 edges, s_chg_mask=4'hA for 1 cycle.
